// File: rtl/seq_tuple_fifo.sv
// seq_tuple_fifo: elastic buffer for the {a__0, b} tuple stream with valid/ready on both sides.
// Define SEQ_TUPLE_FIFO_BYPASS_EN for a zero-latency empty-FIFO bypass path.
module seq_tuple_fifo #(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic [1:0]    I_a__0,
    input  logic [1:0]    I_b,
    input  logic          I_valid,
    output logic          I_ready,
    output logic [1:0]    O_a__0,
    output logic [1:0]    O_b,
    output logic          O_valid,
    input  logic          O_ready,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [3:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic rst_q, empty, push, pop, wr, rd;
    assign empty = count == '0;
    // I_ready uses registered state only, so a pop never frees a full slot in the same cycle
    assign I_ready = rst_q & (count != CW'(DEPTH));
    assign push = I_valid & I_ready;
    assign pop = O_valid & O_ready;
    assign rd = pop & ~empty;
`ifdef SEQ_TUPLE_FIFO_BYPASS_EN
    assign O_valid = empty ? I_valid : 1'b1;
    assign {O_b, O_a__0} = empty ? {I_b, I_a__0} : mem[rp];
    assign wr = push & ~(empty & O_ready);
`else
    assign O_valid = ~empty;
    assign {O_b, O_a__0} = mem[rp];
    assign wr = push;
`endif
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            rst_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rst_q <= 1'b1;
            if (wr) mem[wp] <= {I_b, I_a__0};
            wp <= wp + AW'(wr);
            rp <= rp + AW'(rd);
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: tb/tb_seq_tuple_fifo.sv
// tb_seq_tuple_fifo: directed stimulus with a scoreboard queue checked by a decoupled output monitor.
module tb_seq_tuple_fifo;
    logic       CLK = 1'b0;
    logic       RESETN;
    logic [1:0] I_a__0, I_b, O_a__0, O_b;
    logic       I_valid, I_ready, O_valid, O_ready;
    logic [2:0] count;
    logic [3:0] q[$];
    int tests = 0;
    int fails = 0;
    seq_tuple_fifo #(.DEPTH(4)) dut (
        .CLK(CLK), .RESETN(RESETN), .I_a__0(I_a__0), .I_b(I_b), .I_valid(I_valid),
        .I_ready(I_ready), .O_a__0(O_a__0), .O_b(O_b), .O_valid(O_valid),
        .O_ready(O_ready), .count(count)
    );
    always #5 CLK = ~CLK;
    task automatic chk(string n, logic [7:0] got, logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask
    task automatic drive(bit v, logic [3:0] d, bit r);
        I_valid = v;
        {I_b, I_a__0} = d;
        O_ready = r;
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    // transfers are committed at the next rising edge; sample mid-cycle
    always @(negedge CLK) begin
        if (RESETN && O_valid && O_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected: got %0h expected none", {O_b, O_a__0});
            end else begin
                logic [3:0] e;
                e = q.pop_front();
                if ({O_b, O_a__0} !== e) begin
                    fails++;
                    $display("FAIL out_data: got %0h expected %0h", {O_b, O_a__0}, e);
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        int idx, cyc;
        RESETN = 1'b0;
        drive(0, 4'h0, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_ovalid", 8'(O_valid), 8'd0);
        chk("rst_data", 8'({O_b, O_a__0}), 8'd0);
        chk("rst_iready", 8'(I_ready), 8'd0);
        RESETN = 1'b1;
        #1;
        chk("rel_iready0", 8'(I_ready), 8'd0);
        tick();
        chk("rel_iready1", 8'(I_ready), 8'd1);
        drive(1, 4'b0110, 0);
        q.push_back(4'b0110);
        tick();
        chk("single_ovalid", 8'(O_valid), 8'd1);
        chk("single_a", 8'(O_a__0), 8'd2);
        chk("single_b", 8'(O_b), 8'd1);
        chk("single_count", 8'(count), 8'd1);
        drive(0, 4'h0, 1);
        tick();
        chk("single_drained_count", 8'(count), 8'd0);
        chk("single_drained_ovalid", 8'(O_valid), 8'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'(i), 0);
            q.push_back(4'(i));
            tick();
        end
        chk("fill_count", 8'(count), 8'd4);
        chk("full_iready", 8'(I_ready), 8'd0);
        drive(1, 4'h5, 0);
        tick();
        chk("overflow_count", 8'(count), 8'd4);
        drive(1, 4'h6, 1);
        tick();
        chk("full_pop_count", 8'(count), 8'd3);
        drive(1, 4'h7, 1);
        q.push_back(4'h7);
        tick();
        chk("pushpop_count1", 8'(count), 8'd3);
        drive(1, 4'h8, 1);
        q.push_back(4'h8);
        tick();
        chk("pushpop_count2", 8'(count), 8'd3);
        drive(0, 4'h0, 1);
        repeat (3) tick();
        chk("drain_count", 8'(count), 8'd0);
        chk("drain_queue", 8'(q.size()), 8'd0);
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 60) begin
            drive(1, 4'(idx), cyc[0]);
            if (I_ready) begin
                q.push_back(4'(idx));
                idx++;
            end
            tick();
            cyc++;
        end
        chk("wrap_accepted", 8'(idx), 8'd10);
        drive(0, 4'h0, 1);
        cyc = 0;
        while (count != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("wrap_count", 8'(count), 8'd0);
        chk("wrap_queue", 8'(q.size()), 8'd0);
        drive(1, 4'h9, 0);
        q.push_back(4'h9);
        tick();
        drive(1, 4'hA, 0);
        q.push_back(4'hA);
        tick();
        chk("mid_count2", 8'(count), 8'd2);
        RESETN = 1'b0;
        drive(1, 4'hB, 1);
        q.delete();
        tick();
        chk("mid_rst_count", 8'(count), 8'd0);
        chk("mid_rst_ovalid", 8'(O_valid), 8'd0);
        RESETN = 1'b1;
        drive(0, 4'h0, 0);
        repeat (2) tick();
        chk("mid_after_count", 8'(count), 8'd0);
        chk("mid_after_ovalid", 8'(O_valid), 8'd0);
        chk("mid_after_data", 8'({O_b, O_a__0}), 8'd0);
`ifdef SEQ_TUPLE_FIFO_BYPASS_EN
        drive(1, 4'hD, 1);
        q.push_back(4'hD);
        #1;
        chk("byp_ovalid", 8'(O_valid), 8'd1);
        chk("byp_data", 8'({O_b, O_a__0}), 8'hD);
        tick();
        chk("byp_count", 8'(count), 8'd0);
        drive(0, 4'h0, 0);
`endif
        tick();
        chk("final_queue", 8'(q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
